uart_packetizer: RTL and testbench

//  Frames a wide result word (e.g. spin-state snapshot) into a byte packet for the UART TX.

---
 rtl/uart_packetizer.sv | 113 +++++++++++
 tb/tb_uart_packetizer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packetizer.sv
// uart_packetizer
// Frames a wide result word into a byte packet for the UART transmitter:
// HEADER byte, NBYTES payload bytes (least significant byte first), then an
// 8-bit checksum that is the modulo-256 sum of the payload bytes.
// DATA_WIDTH must be a multiple of 8 and at least 8.
module uart_packetizer #(
  parameter int         DATA_WIDTH = 64,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_in_valid,
  output logic                  word_in_ready,
  output logic [7:0]            data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  // Keep the index at least one bit wide so DATA_WIDTH=8 still elaborates.
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    CSUM
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [7:0]            r_csum;
  logic [IW-1:0]         r_idx;
  logic [7:0]            r_data;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_transfer;
  logic [7:0]            w_sum_next;

  // Only an idle packetizer takes a word, and never while reset is held.
  assign word_in_ready  = (r_state == IDLE) & ~reset;
  assign w_accept       = word_in_valid & word_in_ready;
  assign w_transfer     = r_valid & data_out_ready;
  // Running checksum including the payload byte currently on data_out.
  assign w_sum_next     = r_csum + r_data;

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign busy           = (r_state != IDLE);

  // Packet sequencer: header, payload bytes from the shift register, checksum.
  // The payload is consumed from the bottom of r_shift, so r_shift[7:0] is
  // always the next payload byte to present once the current one transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_csum  <= 8'h00;
      r_idx   <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= word_in;
            r_csum  <= 8'h00;
            r_idx   <= '0;
            r_data  <= HEADER;
            r_valid <= 1'b1;
            r_state <= HDR;
          end
        end
        HDR: begin
          if (w_transfer) begin
            r_data  <= r_shift[7:0];
            r_shift <= r_shift >> 8;
            r_idx   <= '0;
            r_state <= PAY;
          end
        end
        PAY: begin
          if (w_transfer) begin
            r_csum <= w_sum_next;
            if (r_idx == LAST_IDX) begin
              r_data  <= w_sum_next;
              r_state <= CSUM;
            end else begin
              r_data  <= r_shift[7:0];
              r_shift <= r_shift >> 8;
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (w_transfer) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packetizer.sv
// tb_uart_packetizer
// Drives a 64-bit and an 8-bit packetizer with directed and random words and
// random backpressure; a reference model queues the expected bytes of every
// packet and per-instance monitors compare each transferred byte.
module tb_uart_packetizer;

  localparam logic [7:0] HEADER = 8'hA5;

  logic        clk;
  int          checks;
  int          failures;

  // 64-bit instance
  logic        resetA;
  logic [63:0] wordInA;
  logic        wordInValidA;
  logic        wordInReadyA;
  logic [7:0]  dataOutA;
  logic        dataOutValidA;
  logic        dataOutReadyA;
  logic        busyA;
  int          readyModeA;
  logic [7:0]  expQA[$];
  int          transfersA;
  bit          stallA;
  logic [7:0]  heldA;

  // 8-bit instance
  logic        resetB;
  logic [7:0]  wordInB;
  logic        wordInValidB;
  logic        wordInReadyB;
  logic [7:0]  dataOutB;
  logic        dataOutValidB;
  logic        dataOutReadyB;
  logic        busyB;
  logic [7:0]  expQB[$];
  bit          stallB;
  logic [7:0]  heldB;

  uart_packetizer #(.DATA_WIDTH(64), .HEADER(HEADER)) dutA (
    .clk           (clk),
    .reset         (resetA),
    .word_in       (wordInA),
    .word_in_valid (wordInValidA),
    .word_in_ready (wordInReadyA),
    .data_out      (dataOutA),
    .data_out_valid(dataOutValidA),
    .data_out_ready(dataOutReadyA),
    .busy          (busyA)
  );

  uart_packetizer #(.DATA_WIDTH(8), .HEADER(HEADER)) dutB (
    .clk           (clk),
    .reset         (resetB),
    .word_in       (wordInB),
    .word_in_valid (wordInValidB),
    .word_in_ready (wordInReadyB),
    .data_out      (dataOutB),
    .data_out_valid(dataOutValidB),
    .data_out_ready(dataOutReadyB),
    .busy          (busyB)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: header, payload bytes LSB first, modulo-256 payload sum.
  task automatic modelPacket(input logic [63:0] w, input int nbytes, input bit forB);
    logic [7:0] b;
    int         sum;
    sum = 0;
    if (forB) expQB.push_back(HEADER); else expQA.push_back(HEADER);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((w >> (8 * i)) & 64'hFF);
      sum = sum + int'(b);
      if (forB) expQB.push_back(b); else expQA.push_back(b);
    end
    b = 8'(sum % 256);
    if (forB) expQB.push_back(b); else expQA.push_back(b);
  endtask

  // Ready generators: mode 0 always ready, mode 1 random, mode 2 stimulus-owned.
  always @(posedge clk) begin
    #1;
    if (readyModeA == 0) dataOutReadyA = 1'b1;
    else if (readyModeA == 1) dataOutReadyA = 1'($urandom_range(0, 1));
    dataOutReadyB = ($urandom_range(0, 3) != 0);
  end

  // Monitor A: compare every transfer with the scoreboard, check stalls hold.
  always @(negedge clk) begin
    if (resetA) begin
      stallA = 1'b0;
    end else begin
      if (stallA)
        checkOutput("holdA", {55'd0, dataOutValidA, dataOutA}, {55'd0, 1'b1, heldA});
      if (dataOutValidA && dataOutReadyA) begin
        if (expQA.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedA actual=%0h expected=none", dataOutA);
        end else begin
          checkOutput("byteA", 64'(dataOutA), 64'(expQA.pop_front()));
        end
        transfersA++;
      end
      stallA = dataOutValidA && !dataOutReadyA;
      heldA  = dataOutA;
    end
  end

  // Monitor B: same checks for the 8-bit instance.
  always @(negedge clk) begin
    if (resetB) begin
      stallB = 1'b0;
    end else begin
      if (stallB)
        checkOutput("holdB", {55'd0, dataOutValidB, dataOutB}, {55'd0, 1'b1, heldB});
      if (dataOutValidB && dataOutReadyB) begin
        if (expQB.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedB actual=%0h expected=none", dataOutB);
        end else begin
          checkOutput("byteB", 64'(dataOutB), 64'(expQB.pop_front()));
        end
      end
      stallB = dataOutValidB && !dataOutReadyB;
      heldB  = dataOutB;
    end
  end

  // Offer a word to A, queue its packet, and check the header appears next cycle.
  task automatic applyStimulus(input logic [63:0] w);
    int n;
    n = 0;
    while (!wordInReadyA && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("readyA", 64'(wordInReadyA), 64'd1);
    wordInA      = w;
    wordInValidA = 1'b1;
    modelPacket(w, 8, 1'b0);
    @(posedge clk); #1;
    wordInValidA = 1'b0;
    wordInA      = {$urandom, $urandom};
    checkOutput("latencyA", {55'd0, dataOutValidA, dataOutA}, {55'd0, 1'b1, HEADER});
  endtask

  task automatic applyStimulusB(input logic [7:0] w);
    int n;
    n = 0;
    while (!wordInReadyB && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("readyB", 64'(wordInReadyB), 64'd1);
    wordInB      = w;
    wordInValidB = 1'b1;
    modelPacket(64'(w), 1, 1'b1);
    @(posedge clk); #1;
    wordInValidB = 1'b0;
    wordInB      = 8'($urandom);
    checkOutput("latencyB", {55'd0, dataOutValidB, dataOutB}, {55'd0, 1'b1, HEADER});
  endtask

  task automatic drainA();
    int n;
    n = 0;
    while ((expQA.size() != 0 || busyA) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drainA", 64'(expQA.size() == 0 && !busyA), 64'd1);
  endtask

  task automatic drainB();
    int n;
    n = 0;
    while ((expQB.size() != 0 || busyB) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drainB", 64'(expQB.size() == 0 && !busyB), 64'd1);
  endtask

  initial begin
    int n;
    int base;
    checks        = 0;
    failures      = 0;
    transfersA    = 0;
    resetA        = 1'b1;
    resetB        = 1'b1;
    wordInA       = '0;
    wordInValidA  = 1'b0;
    wordInB       = '0;
    wordInValidB  = 1'b0;
    dataOutReadyA = 1'b1;
    dataOutReadyB = 1'b1;
    readyModeA    = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstA", {59'd0, wordInReadyA, dataOutValidA, busyA, 1'b0, |dataOutA}, 64'd0);
    checkOutput("rstB", {59'd0, wordInReadyB, dataOutValidB, busyB, 1'b0, |dataOutB}, 64'd0);
    resetA = 1'b0;
    resetB = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstReleaseA", 64'(wordInReadyA), 64'd1);

    // Nominal packet, ready always high: busy for exactly NBYTES+2 cycles
    applyStimulus(64'h0807060504030201);
    n = 0;
    while (busyA && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("busyCycles", 64'(n), 64'd10);
    drainA();

    // Backpressure while 0x03 is presented
    readyModeA    = 2;
    dataOutReadyA = 1'b1;
    applyStimulus(64'h0807060504030201);
    n = 0;
    while (!(dataOutValidA && dataOutA == 8'h03) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    dataOutReadyA = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bpHold", {55'd0, dataOutValidA, dataOutA}, {55'd0, 1'b1, 8'h03});
    dataOutReadyA = 1'b1;
    readyModeA    = 0;
    drainA();

    // Checksum wrap
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);
    drainA();

    // Back-to-back: valid held, second word zero
    wordInA      = 64'h0807060504030201;
    wordInValidA = 1'b1;
    modelPacket(64'h0807060504030201, 8, 1'b0);
    modelPacket(64'h0, 8, 1'b0);
    @(posedge clk); #1;
    wordInA = 64'h0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 10)
        checkOutput("b2bBusy", {62'd0, busyA, wordInReadyA}, 64'b10);
      else if (k == 11)
        checkOutput("b2bBubble", {62'd0, busyA, wordInReadyA}, 64'b01);
      else
        checkOutput("b2bSecond", 64'(busyA), 64'd1);
      if (k < 12) begin
        @(posedge clk); #1;
      end
    end
    wordInValidA = 1'b0;
    drainA();

    // Reset mid-payload after byte 0x04 transfers
    base = transfersA;
    applyStimulus(64'h0807060504030201);
    n = 0;
    while (transfersA < base + 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    resetA = 1'b1;
    expQA.delete();
    @(posedge clk); #1;
    checkOutput("midReset", {61'd0, dataOutValidA, busyA, wordInReadyA}, 64'd0);
    resetA = 1'b0;
    @(posedge clk); #1;
    applyStimulus(64'h0807060504030201);
    drainA();

    // Random words under random backpressure
    readyModeA = 1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus({$urandom, $urandom});
      drainA();
    end
    readyModeA = 0;

    // 8-bit instance: single payload byte, checksum equals it
    applyStimulusB(8'h5A);
    drainB();
    for (int k = 0; k < 15; k++) begin
      applyStimulusB(8'($urandom));
      drainB();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
